// File: rtl/dsc_mul_seq.sv
`default_nettype none
//==============================================================================
//  Module      : dsc_mul_seq
//  Description : Sequencer for a 2-input deterministic stochastic multiply.
//                Accepts an (a,b) pair, generates two deterministic unary
//                streams in the clock-division schedule (A full rate, B one
//                step per A period), accumulates their AND into a binary
//                product and returns product plus run length.
//  Revision    : 1.0 - initial release
//==============================================================================
module dsc_mul_seq #(
    parameter int W          = 8,
    parameter bit EARLY_STOP = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           abort,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] z,
    output logic [2*W:0]   cycles,
    output logic           busy,
    output logic           last,
    output logic           sn_a,
    output logic           sn_b,
    output logic           sn_mul
);

    // State encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Increment constants sized to each counter
    localparam logic [W-1:0]   c_ONE_W   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W:0]   c_ONE_CNT = {{(2*W){1'b0}}, 1'b1};

    logic [1:0]     r_state;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_ia;
    logic [W-1:0]   r_ib;
    logic [2*W-1:0] r_acc;
    logic [2*W:0]   r_cnt;
    logic [2*W-1:0] r_z;
    logic [2*W:0]   r_cycles;

    logic           w_idle;
    logic           w_run;
    logic           w_done;
    logic           w_accept;
    logic           w_shortcut;
    logic           w_sn_a;
    logic           w_sn_b;
    logic           w_sn_mul;
    logic           w_ia_wrap;
    logic           w_ib_end;
    logic           w_last;
    logic [2*W-1:0] w_acc_next;
    logic [2*W:0]   w_cnt_next;

    assign w_idle   = (r_state == c_IDLE);
    assign w_run    = (r_state == c_RUN);
    assign w_done   = (r_state == c_DONE);
    assign w_accept = w_idle & in_valid;

    // A zero operand means the product is known without running any stream
    assign w_shortcut = EARLY_STOP & ((a == '0) | (b == '0));

    // Unary streams: comparator against the position inside each stream
    assign w_sn_a   = w_run & (r_ia < r_a);
    assign w_sn_b   = w_run & (r_ib < r_b);
    assign w_sn_mul = w_sn_a & w_sn_b;

    // ia wraps after 2^W cycles, which is when stream B takes its next step
    assign w_ia_wrap = &r_ia;

    // Where the B stream ends decides the run length
    generate
        if (EARLY_STOP) begin : g_early_stop
            // Past b_reg periods stream B is all zeros, so nothing more to add
            assign w_ib_end = (r_ib == (r_b - c_ONE_W));
        end else begin : g_full_run
            assign w_ib_end = &r_ib;
        end
    endgenerate

    assign w_last     = w_run & w_ia_wrap & w_ib_end;
    assign w_acc_next = r_acc + {{(2*W-1){1'b0}}, w_sn_mul};
    assign w_cnt_next = r_cnt + c_ONE_CNT;

    // Control FSM: IDLE -> RUN/DONE -> IDLE, abort returns to IDLE from RUN/DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_state <= w_shortcut ? c_DONE : c_RUN;
                    end
                end
                c_RUN: begin
                    if (abort) begin
                        r_state <= c_IDLE;
                    end else if (w_last) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready || abort) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Operand capture and stream position / accumulator datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_ia  <= '0;
            r_ib  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_ia  <= '0;
            r_ib  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_run && !abort) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            r_ia  <= r_ia + c_ONE_W;
            if (w_ia_wrap) begin
                r_ib <= r_ib + c_ONE_W;
            end
        end
    end

    // Committed result: written only on entry to DONE, otherwise held
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_z      <= '0;
            r_cycles <= '0;
        end else if (w_accept && w_shortcut) begin
            r_z      <= '0;
            r_cycles <= '0;
        end else if (w_last && !abort) begin
            // The final cycle's stream bit is part of the product
            r_z      <= w_acc_next;
            r_cycles <= w_cnt_next;
        end
    end

    assign in_ready  = w_idle;
    assign out_valid = w_done;
    assign busy      = w_run;
    assign last      = w_last;
    assign sn_a      = w_sn_a;
    assign sn_b      = w_sn_b;
    assign sn_mul    = w_sn_mul;
    assign z         = r_z;
    assign cycles    = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_dsc_mul_seq.sv
`default_nettype none
//==============================================================================
//  Module      : tb_dsc_mul_seq
//  Description : Self-checking bench for dsc_mul_seq at W=3 with one instance
//                per EARLY_STOP setting (index 0: EARLY_STOP=1, index 1: 0).
//                Expected values come from plain arithmetic on the operands.
//  Revision    : 1.0 - initial release
//==============================================================================
module tb_dsc_mul_seq;

    localparam int W = 3;
    localparam int P = 1 << W;   // A-stream period

    logic           clk;
    logic           rst;
    logic           in_valid_s  [2];
    logic           in_ready_s  [2];
    logic [W-1:0]   a_s         [2];
    logic [W-1:0]   b_s         [2];
    logic           abort_s     [2];
    logic           out_valid_s [2];
    logic           out_ready_s [2];
    logic [2*W-1:0] z_s         [2];
    logic [2*W:0]   cyc_s       [2];
    logic           busy_s      [2];
    logic           last_s      [2];
    logic           sn_a_s      [2];
    logic           sn_b_s      [2];
    logic           sn_mul_s    [2];

    int n_checks;
    int n_errors;
    int exp_z_last   [2];
    int exp_cyc_last [2];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            dsc_mul_seq #(
                .W          (W),
                .EARLY_STOP (g == 0)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid_s[g]),
                .in_ready  (in_ready_s[g]),
                .a         (a_s[g]),
                .b         (b_s[g]),
                .abort     (abort_s[g]),
                .out_valid (out_valid_s[g]),
                .out_ready (out_ready_s[g]),
                .z         (z_s[g]),
                .cycles    (cyc_s[g]),
                .busy      (busy_s[g]),
                .last      (last_s[g]),
                .sn_a      (sn_a_s[g]),
                .sn_b      (sn_b_s[g]),
                .sn_mul    (sn_mul_s[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference run length from the operands and the stop mode
    function automatic int exp_cycles(input int d, input int av, input int bv);
        if (d == 0) return (av == 0 || bv == 0) ? 0 : bv * P;
        return P * P;
    endfunction

    // One full transaction: accept, observe the run, hold in DONE, release.
    // rel: 0 = out_ready, 1 = abort, 2 = both
    task automatic run_op(input int d, input int av, input int bv,
                          input int hold, input int rel, input bit abort_acc);
        int ec, k, pop, bsy, lastn, lastk, mism, lat, stab;
        logic ea, eb;
        ec = exp_cycles(d, av, bv);
        k = 0; pop = 0; bsy = 0; lastn = 0; lastk = -1; mism = 0; stab = 0;
        @(negedge clk);
        chk("in_ready_idle", in_ready_s[d], 1);
        in_valid_s[d] = 1'b1;
        a_s[d]        = W'(av);
        b_s[d]        = W'(bv);
        abort_s[d]    = abort_acc;
        @(negedge clk);
        in_valid_s[d] = 1'b0;
        abort_s[d]    = 1'b0;
        a_s[d]        = W'($urandom);
        b_s[d]        = W'($urandom);
        lat = 1;
        while (!out_valid_s[d] && lat <= ec + 5) begin
            if (busy_s[d]) begin
                ea = ((k % P) < av);
                eb = ((k / P) < bv);
                if (sn_a_s[d] != ea || sn_b_s[d] != eb || sn_mul_s[d] != (ea & eb))
                    mism++;
                pop += int'(sn_mul_s[d]);
                bsy++;
                if (last_s[d]) begin
                    lastn++;
                    lastk = k;
                end
                k++;
            end else if (sn_a_s[d] || sn_b_s[d] || sn_mul_s[d] || last_s[d]) begin
                mism++;
            end
            if (in_ready_s[d]) mism++;
            @(negedge clk);
            lat++;
        end
        chk("out_valid", out_valid_s[d], 1);
        chk("latency", lat, 1 + ec);
        chk("busy_cycles", bsy, ec);
        chk("last_count", lastn, (ec > 0) ? 1 : 0);
        chk("last_pos", lastk, ec - 1);
        chk("popcount", pop, av * bv);
        chk("stream_mism", mism, 0);
        chk("z", z_s[d], av * bv);
        chk("cycles", cyc_s[d], ec);
        repeat (hold) begin
            @(negedge clk);
            if (!out_valid_s[d] || z_s[d] != (2*W)'(av * bv) || int'(cyc_s[d]) != ec ||
                in_ready_s[d] || busy_s[d] || sn_mul_s[d])
                stab++;
        end
        chk("hold_stable", stab, 0);
        out_ready_s[d] = (rel != 1);
        abort_s[d]     = (rel != 0);
        @(negedge clk);
        out_ready_s[d] = 1'b0;
        abort_s[d]     = 1'b0;
        chk("out_valid_drop", out_valid_s[d], 0);
        chk("in_ready_rise", in_ready_s[d], 1);
        chk("z_retained", z_s[d], av * bv);
        chk("cycles_retained", cyc_s[d], ec);
        exp_z_last[d]   = av * bv;
        exp_cyc_last[d] = ec;
    endtask

    // Accept a pair, abort it after 'at' RUN cycles, check nothing was committed
    task automatic abort_run(input int d, input int av, input int bv, input int at);
        @(negedge clk);
        in_valid_s[d] = 1'b1;
        a_s[d]        = W'(av);
        b_s[d]        = W'(bv);
        @(negedge clk);
        in_valid_s[d] = 1'b0;
        repeat (at) @(negedge clk);
        chk("abort_in_run", busy_s[d], 1);
        abort_s[d] = 1'b1;
        @(negedge clk);
        abort_s[d] = 1'b0;
        chk("abort_out_valid", out_valid_s[d], 0);
        chk("abort_in_ready", in_ready_s[d], 1);
        chk("abort_busy", busy_s[d], 0);
        chk("abort_z", z_s[d], exp_z_last[d]);
        chk("abort_cycles", cyc_s[d], exp_cyc_last[d]);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid_s[d]  = 1'b0;
            a_s[d]         = '0;
            b_s[d]         = '0;
            abort_s[d]     = 1'b0;
            out_ready_s[d] = 1'b0;
            exp_z_last[d]  = 0;
            exp_cyc_last[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", in_ready_s[d], 1);
            chk("rst_out_valid", out_valid_s[d], 0);
            chk("rst_busy", busy_s[d], 0);
            chk("rst_last", last_s[d], 0);
            chk("rst_z", z_s[d], 0);
            chk("rst_cycles", cyc_s[d], 0);
            chk("rst_sn_mul", sn_mul_s[d], 0);
        end
        rst = 1'b1;

        // Zero-operand shortcut and a first nonzero product
        run_op(0, 7, 0, 2, 0, 1'b0);
        run_op(0, 0, 5, 0, 0, 1'b0);
        run_op(0, 4, 4, 0, 0, 1'b0);

        // Exhaustive sweep on both stop modes with random backpressure
        for (int d = 0; d < 2; d++)
            for (int av = 0; av < P; av++)
                for (int bv = 0; bv < P; bv++)
                    run_op(d, av, bv, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);

        // Randomized transactions
        for (int i = 0; i < 30; i++)
            run_op($urandom_range(0, 1), $urandom_range(0, P-1), $urandom_range(0, P-1),
                   $urandom_range(0, 6), $urandom_range(0, 2), 1'b0);

        // abort in IDLE has no effect; abort together with accept loses
        @(negedge clk);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        chk("abort_idle_in_ready", in_ready_s[0], 1);
        chk("abort_idle_out_valid", out_valid_s[0], 0);
        run_op(0, 3, 4, 1, 0, 1'b1);
        run_op(1, 5, 2, 1, 0, 1'b1);

        // Randomized mid-run aborts
        for (int i = 0; i < 20; i++) begin
            int d, av, bv;
            d  = $urandom_range(0, 1);
            av = $urandom_range(1, P-1);
            bv = $urandom_range(1, P-1);
            abort_run(d, av, bv, $urandom_range(0, exp_cycles(d, av, bv) - 1));
        end

        // Reset in the middle of a run
        @(negedge clk);
        in_valid_s[0] = 1'b1;
        a_s[0] = W'(6);
        b_s[0] = W'(5);
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", busy_s[0], 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_in_ready", in_ready_s[0], 1);
        chk("midrst_out_valid", out_valid_s[0], 0);
        chk("midrst_busy", busy_s[0], 0);
        chk("midrst_last", last_s[0], 0);
        chk("midrst_sn_mul", sn_mul_s[0], 0);
        chk("midrst_z", z_s[0], 0);
        chk("midrst_cycles", cyc_s[0], 0);
        for (int d = 0; d < 2; d++) begin
            exp_z_last[d]   = 0;
            exp_cyc_last[d] = 0;
        end
        run_op(0, 4, 4, 0, 0, 1'b0);
        run_op(1, 4, 4, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dsc_mul_seq.md
Name: dsc_mul_seq

Overview:
Sequencer for the 2-input deterministic stochastic multiply: accepts (a,b) operand pairs over a valid/ready handshake and generates the two deterministic unary bit-streams internally. In the clock-division schedule, stream A runs full-rate and stream B advances once per A period. It accumulates the AND of the streams into a 2W-bit binary result and terminates early once stream B is exhausted. It reports result and run length over a second valid/ready handshake, and exports the live streams for probing.

Parameters:
W, 8, operand / stream-generator width; A period = 2^W cycles
EARLY_STOP, 1, 1 = stop after b*2^W cycles (B stream known zero thereafter); 0 = always run full 2^(2W) cycles

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
in_valid  in  1  operand pair offered
in_ready  out  1  high only in IDLE
a  in  W  operand A, sampled on in_valid&in_ready
b  in  W  operand B, sampled on in_valid&in_ready
abort  in  1  synchronous cancel of current operation
out_valid  out  1  result available (DONE state)
out_ready  in  1  consumer accepts result
z  out  2W  product count, equals a*b
cycles  out  2W+1  number of RUN cycles used for this result
busy  out  1  high in RUN
last  out  1  high during final RUN cycle
sn_a  out  1  stream A bit this cycle
sn_b  out  1  stream B bit this cycle
sn_mul  out  1  sn_a & sn_b

Behaviour:
- Reset (rst==0 at clk edge): state IDLE; in_ready=1; out_valid=0, busy=0, last=0; z=0, cycles=0; internal a_reg, b_reg, ia, ib, acc, cnt=0. Reset dominates abort and all handshakes, in any state.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid: latch a_reg=a, b_reg=b; clear ia, ib, acc, cnt.
  - EARLY_STOP=1 and (a==0 or b==0): go directly to DONE with z=0, cycles=0. out_valid is high the cycle after acceptance.
  - Otherwise: go to RUN.
- RUN, each cycle:
  - sn_a=(ia<a_reg), sn_b=(ib<b_reg), sn_mul=sn_a&sn_b (combinational from registers).
  - acc+=sn_mul; cnt+=1; ia+=1 (wraps at 2^W); on ia wrap, ib+=1.
- RUN termination:
  - EARLY_STOP=1: last=1 when ia==2^W-1 and ib==b_reg-1.
  - EARLY_STOP=0: last=1 when ia==2^W-1 and ib==2^W-1.
  - The last cycle's sn_mul is included. Next state DONE with z=final acc, cycles=final cnt.
  - Run lengths: b*2^W cycles with EARLY_STOP=1; 2^(2W) cycles with EARLY_STOP=0.
- Stream outputs outside RUN: sn_a=sn_b=sn_mul=0.
- DONE: out_valid=1; z and cycles held stable while out_ready=0. On out_ready, go to IDLE. out_valid drops the next cycle, and in_ready rises that same cycle.
- z and cycles:
  - Updated only on entry to DONE; retain their value in IDLE until the next DONE.
  - z==a*b always.
  - Widths never overflow: max a*b=(2^W-1)^2 < 2^(2W); max cycles=2^(2W) fits 2W+1 bits.
- abort:
  - In RUN or DONE: next state IDLE, out_valid=0, z/cycles unchanged from their prior committed values.
  - Ignored in IDLE. Also ignored on the cycle a new pair is accepted; the accept wins.
  - abort and out_ready together in DONE: result counts as consumed; next state IDLE.
- in_valid while not IDLE: ignored (in_ready=0); no operand buffering.
- Total latency, accept edge to out_valid: 1+run_cycles clock cycles.

Test Plan:
- Nominal, EARLY_STOP=1: a=128, b=128, out_ready=1 -> busy for 32768 cycles, last pulses once; z=16384, cycles=32768; popcount of sn_mul over the run = 16384.
- Maximum, EARLY_STOP=1: a=255, b=255 -> z=65025, cycles=65280. Zero-operand shortcut: a=77, b=0 -> out_valid one cycle after accept, z=0, cycles=0, busy never asserted.
- EARLY_STOP=0: a=3, b=5 -> z=15, cycles=65536; sn_b high for the first 1280 RUN cycles only; sn_a high for ia in 0..2 of each 256-cycle period.
- Backpressure: a=10, b=2, out_ready held 0 for 20 cycles after out_valid -> z=20, cycles=512 stable, in_ready=0 throughout. Raise out_ready -> IDLE next cycle; a back-to-back pair is accepted that cycle.
- Abort/reset mid-run:
  - abort at RUN cycle 100 of a=200, b=50 -> IDLE next cycle, no out_valid, z retains previous result.
  - rst=0 at RUN cycle 100 -> all outputs return to reset values next edge.
  - A subsequent a=4, b=4 completes with z=16, cycles=1024.
- Exhaustive small sweep, W=3 both EARLY_STOP settings: all 64 (a,b) pairs -> z==a*b; cycles==b*8 (EARLY_STOP=1, nonzero operands) or 64 (EARLY_STOP=0).
